shift_seq_8_bit: RTL and testbench
==================================

// Module: shift_seq_8_bit
// PURPOSE
//  Multi-position shift sequencer placed directly upstream of shift_8_bit.
//  Accepts an operand, shift amount, direction and mode over a valid/ready handshake.
//  Each cycle it drives shift_8_bit for one single-position step and recirculates S.
//  Returns the result, the last bit shifted out and an optional sticky bit to the ALU result mux.
// PARAMETERS
//  WIDTH  8  operand width; fixed by shift_8_bit; other values unsupported
//  AMT_W  4  shift-amount width; amount range 0..15
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_data    in   WIDTH  operand
//  in_amt     in   AMT_W  shift amount
//  in_dir     in   1      0 = left, 1 = right; drives shift_8_bit select
//  in_mode    in   2      00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//  out_valid  out  1      result available
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_data   out  WIDTH  shifted result
//  out_carry  out  1      last bit shifted out; 0 when effective amount is 0
//  out_sticky out  1      OR of all bits shifted out; see CONFIGURATION
//  busy       out  1      high in SHIFT and DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0.
//   Reset also clears out_data, out_carry and out_sticky to 0.
//   Asserting reset mid-operation aborts it; the operand is discarded.
//  FSM:
//   IDLE : in_ready=1. On accept, latch data, dir and mode, and load count=eff_amt.
//          If eff_amt==0 go to DONE, else go to SHIFT.
//   SHIFT: in_ready=0. Each cycle reg <= shift_8_bit.S and count <= count-1.
//          At count==1 the final step completes and the FSM goes to DONE.
//   DONE : out_valid=1. Outputs are stable while out_ready=0.
//          On out_ready, go to IDLE. There is no accept in the same cycle;
//          in_ready rises the next cycle.
//  eff_amt: logical and arithmetic saturate at 8 (amt>=8 gives 8 steps); rotate uses amt mod 8.
//  Latency: accept edge to out_valid is eff_amt+1 cycles. Throughput is one op per eff_amt+2 cycles minimum.
//  Fill bit per step:
//   logical: 0
//   arithmetic right: current MSB (sign preserved)
//   arithmetic left: 0
//   rotate: the bit shifted out (bb_left on left, bb_right on right)
//  The fill drives shift_in_right on left shifts and shift_in_left on right shifts.
//  out_carry: bb_left (left) or bb_right (right) of the final step, registered.
//  in_mode 11 behaves exactly as 00. in_valid is ignored outside IDLE.
//  in_* inputs need only be stable in the accept cycle.
// CONFIGURATION
//  SHIFT_SEQ_STICKY_EN defined:
//   Sticky register is cleared on accept and ORs in every shifted-out bit during SHIFT.
//   Rotate mode holds it at 0. out_sticky is valid with out_valid.
//  SHIFT_SEQ_STICKY_EN undefined:
//   No sticky register is built; out_sticky is tied to 0. The port always exists.
// STRUCTURE
//  Package shift_seq_pkg:
//   mode encoding constants MODE_LOG, MODE_ARI, MODE_ROT
//   state encoding IDLE, SHIFT, DONE
//   constants WIDTH=8, AMT_MAX=8
//  One sub-module: shift_8_bit, instanced once as the per-step datapath.
//  FSM, counter, fill logic and output registers stay in this module.
// TESTING
//  1 data=B4, amt=3, right, logical -> out_valid 4 cycles after accept;
//    out_data=16, carry=1, sticky=1.
//  2 data=90, amt=2, right, arithmetic -> out_data=E4, carry=0, sticky=0.
//  3 data=81, amt=1, left, rotate -> out_data=03, carry=1.
//    Repeat with amt=9 -> identical result and latency 2.
//  4 amt=0, data=5A, any mode -> out_valid next cycle; out_data=5A, carry=0, sticky=0.
//  5 data=FF, amt=12, left, logical -> saturate to 8 steps, latency 9;
//    out_data=00, carry=1.
//  6 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//    Then assert rst_n=0 mid-SHIFT of a new op -> immediately IDLE,
//    out_valid=0, in_ready=1.

Source files
------------

// File: rtl/shift_seq_8_bit_pkg.sv
// shift_seq_8_bit_pkg: shared constants, state/mode encodings and effective-amount helper
//   Optional feature macro used by the top: SHIFT_SEQ_STICKY_EN
package shift_seq_pkg;
    localparam int WIDTH = 8;
    localparam int AMT_W = 4;
    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(8);
    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    // Rotate wraps modulo the width; logical/arithmetic saturate at the width.
    function automatic logic [AMT_W-1:0] eff_amt(input logic [AMT_W-1:0] amt, input logic [1:0] mode);
        return (mode == MODE_ROT) ? (amt & AMT_W'(WIDTH-1)) : ((amt > AMT_MAX) ? AMT_MAX : amt);
    endfunction
endpackage

// File: rtl/shift_seq_8_bit_if.sv
// shift_seq_if: request/response bundle of the shift sequencer
//   master drives in_valid/in_data/in_amt/in_dir/in_mode/out_ready
//   slave drives in_ready/out_valid/out_data/out_carry/out_sticky/busy
interface shift_seq_if import shift_seq_pkg::*; ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_sticky;
    logic             busy;
    modport master (
        output in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_sticky, busy
    );
    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_sticky, busy
    );
endinterface

// File: rtl/shift_seq_8_bit_shift.sv
// shift_8_bit: single-position shifter step
//   i_a operand, i_sel 0=left 1=right, i_shift_in_left/right fill bits
//   o_s result, o_bb_left/o_bb_right bit leaving on the left/right side
module shift_8_bit
    import shift_seq_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_sel,
    input  logic             i_shift_in_left,
    input  logic             i_shift_in_right,
    output logic [WIDTH-1:0] o_s,
    output logic             o_bb_left,
    output logic             o_bb_right
);
    assign o_s        = i_sel ? {i_shift_in_left, i_a[WIDTH-1:1]} : {i_a[WIDTH-2:0], i_shift_in_right};
    assign o_bb_left  = i_a[WIDTH-1];
    assign o_bb_right = i_a[0];
endmodule

// File: rtl/shift_seq_8_bit.sv
// shift_seq_8_bit: multi-position shift sequencer driving shift_8_bit one step per cycle
//   clk, rst_n (async active-low), bus (shift_seq_if.slave)
//   Optional sticky bit built when SHIFT_SEQ_STICKY_EN is defined, else out_sticky=0
module shift_seq_8_bit
    import shift_seq_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    shift_seq_if.slave bus
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_count;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_carry;
    logic [WIDTH-1:0] w_s;
    logic [AMT_W-1:0] w_eff;
    logic             w_accept, w_fill, w_bb_left, w_bb_right, w_out_bit;

    assign w_eff     = eff_amt(bus.in_amt, bus.in_mode);
    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_out_bit = r_dir ? w_bb_right : w_bb_left;
    // Rotate recirculates the outgoing bit; only arithmetic right replicates the sign.
    assign w_fill    = (r_mode == MODE_ROT) ? w_out_bit : ((r_mode == MODE_ARI) && r_dir) ? r_data[WIDTH-1] : 1'b0;

    shift_8_bit u_shift (
        .i_a             (r_data),
        .i_sel           (r_dir),
        .i_shift_in_left (w_fill),
        .i_shift_in_right(w_fill),
        .o_s             (w_s),
        .o_bb_left       (w_bb_left),
        .o_bb_right      (w_bb_right)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = r_state == IDLE;
        bus.out_valid = r_state == DONE;
        bus.busy      = r_state != IDLE;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = (w_eff == '0) ? DONE : SHIFT;
            SHIFT:   if (r_count == AMT_W'(1)) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_mode  <= MODE_LOG;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_data  <= bus.in_data;
            r_count <= w_eff;
            r_dir   <= bus.in_dir;
            r_mode  <= bus.in_mode;
            r_carry <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_data  <= w_s;
            r_count <= r_count - AMT_W'(1);
            r_carry <= w_out_bit;
        end

    assign bus.out_data  = r_data;
    assign bus.out_carry = r_carry;

`ifdef SHIFT_SEQ_STICKY_EN
    logic r_sticky;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                r_sticky <= 1'b0;
        else if (w_accept)         r_sticky <= 1'b0;
        else if (r_state == SHIFT) r_sticky <= r_sticky | (w_out_bit & (r_mode != MODE_ROT));
    assign bus.out_sticky = r_sticky;
`else
    assign bus.out_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_shift_seq_8_bit.sv
// tb_shift_seq_8_bit: scoreboard bench for shift_seq_8_bit
module tb_shift_seq_8_bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       s;
        int         lat;
    } exp_t;

    exp_t sb[$];

    shift_seq_if bus ();

    shift_seq_8_bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic [3:0] a, input logic dir, input logic [1:0] m);
        exp_t e;
        int k;
        logic [15:0] t;
        logic rot;
        rot = (m == 2'b10);
        k = rot ? int'(a) % 8 : (a > 4'd8 ? 8 : int'(a));
        t = {8'h00, d};
        e.lat = k + 1;
        e.c = 1'b0;
        e.s = 1'b0;
        if (rot) begin
            e.d = dir ? 8'((t >> k) | (t << (8 - k))) : 8'((t << k) | (t >> (8 - k)));
            if (k > 0) e.c = dir ? e.d[7] : e.d[0];
        end else if (dir) begin
            e.d = (m == 2'b01) ? 8'($signed(d) >>> k) : 8'(t >> k);
            if (k > 0) begin
                e.c = t[k-1];
                e.s = |(t & ((16'd1 << k) - 16'd1));
            end
        end else begin
            e.d = 8'(t << k);
            if (k > 0) begin
                e.c = t[8-k];
                e.s = |(t >> (8 - k));
            end
        end
`ifndef SHIFT_SEQ_STICKY_EN
        e.s = 1'b0;
`endif
        return e;
    endfunction

    task automatic run_op(input logic [7:0] d, input logic [3:0] a, input logic dir, input logic [1:0] m, input int hold);
        exp_t e;
        int n, lat;
        logic [7:0] held;
        sb.push_back(model(d, a, dir, m));
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dir;
        bus.in_mode  = m;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_amt   = 4'($urandom);
        bus.in_dir   = 1'($urandom);
        bus.in_mode  = 2'($urandom);
        lat = 1;
        if (!bus.out_valid) chk("shift_ready", {31'd0, bus.in_ready}, 0);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("data", {24'd0, bus.out_data}, {24'd0, e.d});
        chk("carry", {31'd0, bus.out_carry}, {31'd0, e.c});
        chk("sticky", {31'd0, bus.out_sticky}, {31'd0, e.s});
        chk("done_busy", {31'd0, bus.busy}, 1);
        held = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.out_valid}, 1);
            chk("hold_data", {24'd0, bus.out_data}, {24'd0, held});
            chk("hold_ready", {31'd0, bus.in_ready}, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_valid", {31'd0, bus.out_valid}, 0);
        chk("release_ready", {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_amt    = 4'h0;
        bus.in_dir    = 1'b0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_ready", {31'd0, bus.in_ready}, 1);
        chk("rst_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_data", {24'd0, bus.out_data}, 0);
        chk("rst_carry", {31'd0, bus.out_carry}, 0);
        chk("rst_sticky", {31'd0, bus.out_sticky}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'hB4, 4'd3, 1'b1, 2'b00, 0);
        run_op(8'h90, 4'd2, 1'b1, 2'b01, 0);
        run_op(8'h81, 4'd1, 1'b0, 2'b10, 0);
        run_op(8'h81, 4'd9, 1'b0, 2'b10, 0);
        for (int m = 0; m < 4; m++) run_op(8'h5A, 4'd0, 1'(m), 2'(m), 0);
        run_op(8'hFF, 4'd12, 1'b0, 2'b00, 0);
        run_op(8'hC3, 4'd5, 1'b1, 2'b11, 5);
        run_op(8'h96, 4'd8, 1'b1, 2'b10, 0);
        run_op(8'hA5, 4'd15, 1'b1, 2'b01, 0);
        for (int i = 0; i < 24; i++)
            run_op(8'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), i % 3);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hE7;
        bus.in_amt   = 4'd8;
        bus.in_dir   = 1'b0;
        bus.in_mode  = 2'b00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, bus.out_valid}, 0);
        chk("abort_ready", {31'd0, bus.in_ready}, 1);
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_data", {24'd0, bus.out_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_valid", {31'd0, bus.out_valid}, 0);
        run_op(8'h3C, 4'd2, 1'b0, 2'b01, 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
